// File: rtl/ex_stage_pkg.sv
// ex_stage_pkg: shared widths, opcode constants and the multiplier state
// type for the execute stage.
// Optional feature macro: RV32M_MUL_EN (adds the MUL/MULH/MULHSU/MULHU opcodes).
package ex_stage_pkg;

   localparam int XLEN            = 32;
   localparam int REG_AW          = 5;
   localparam int ALU_OP_WIDTH    = 4;
   localparam int BRANCH_OP_WIDTH = 3;
   localparam int MEM_OP_WIDTH    = 3;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd1;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd2;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd3;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd4;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'd5;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'd6;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd7;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd8;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd9;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_LUI  = 4'd10;
`ifdef RV32M_MUL_EN
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MUL    = 4'd11;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MULH   = 4'd12;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MULHSU = 4'd13;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_MULHU  = 4'd14;
`endif

   // Branch opcodes follow the RV32 funct3 encoding; 2 and 3 are never taken.
   localparam logic [BRANCH_OP_WIDTH-1:0] BRANCH_OP_BEQ  = 3'd0;
   localparam logic [BRANCH_OP_WIDTH-1:0] BRANCH_OP_BNE  = 3'd1;
   localparam logic [BRANCH_OP_WIDTH-1:0] BRANCH_OP_BLT  = 3'd4;
   localparam logic [BRANCH_OP_WIDTH-1:0] BRANCH_OP_BGE  = 3'd5;
   localparam logic [BRANCH_OP_WIDTH-1:0] BRANCH_OP_BLTU = 3'd6;
   localparam logic [BRANCH_OP_WIDTH-1:0] BRANCH_OP_BGEU = 3'd7;

   // Access size for loads/stores; signedness travels separately on *_unsign.
   localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_B = 3'd0;
   localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_H = 3'd1;
   localparam logic [MEM_OP_WIDTH-1:0] MEM_OP_W = 3'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL1 = 2'd1,
      MUL2 = 2'd2
   } ex_mul_state_t;

endpackage

// File: rtl/ex_stage_mul.sv
// ex_stage_mul: two-step multiplier for the execute stage (present only when
// RV32M_MUL_EN is defined).
//  clk, rst_b : clock, asynchronous active-low reset
//  start      : latch operands (33-bit, sign/zero extended per opcode)
//  step       : register the 64-bit product of the latched operands
//  op         : ALU opcode of the multiply
//  rs1, rs2   : raw register operands
//  result     : product[31:0] for MUL, product[63:32] for the high variants
`ifdef RV32M_MUL_EN
module ex_stage_mul
   import ex_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_b,
   input  logic                    start,
   input  logic                    step,
   input  logic [ALU_OP_WIDTH-1:0] op,
   input  logic [XLEN-1:0]         rs1,
   input  logic [XLEN-1:0]         rs2,
   output logic [XLEN-1:0]         result
);

   logic signed [32:0]        a_q, b_q;
   logic        [63:0]        product_q;
   logic [ALU_OP_WIDTH-1:0]   op_q;
   logic signed [63:0]        product_d;
   logic                      a_signed, b_signed;

   // MUL only needs the low word, which is the same for any extension.
   assign a_signed = (op == ALU_OP_MULH) || (op == ALU_OP_MULHSU);
   assign b_signed = (op == ALU_OP_MULH);

   // Extending both operands to 64 bits keeps the low 64 bits of the
   // 33x33 product exact.
   assign product_d = 64'(a_q) * 64'(b_q);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         product_q <= '0;
      end else begin
         if (start) begin
            a_q  <= {a_signed & rs1[31], rs1};
            b_q  <= {b_signed & rs2[31], rs2};
            op_q <= op;
         end
         if (step) begin
            product_q <= product_d;
         end
      end
   end

   assign result = (op_q == ALU_OP_MUL) ? product_q[31:0] : product_q[63:32];

endmodule
`endif

// File: rtl/ex_stage.sv
// ex_stage: RV32 execute stage. Takes the ID bundle, computes the ALU result,
// resolves branches/jumps (redirect to IF, flush to ID) and registers the
// payload into the EX->MEM pipeline register.
// Optional feature macro: RV32M_MUL_EN adds the multiply unit and its FSM.
// Ports:
//  clk, rst_b                     clock, asynchronous active-low reset
//  ex_pipe_valid/ex_pipe_ready    ID->EX handshake
//  ex_* operands and control      bundle from ID
//  ex_redirect, ex_redirect_pc    taken branch/jump, combinational on fire
//  mem_pipe_valid/mem_pipe_ready  EX->MEM handshake
//  mem_* payload and control      registered bundle for MEM
//  mul_state                      multiplier FSM state (IDLE when no multiplier)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high; the producer holds valid and its payload stable until that edge, and
// ready never depends on anything but the consumer's own state and opcode.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic                       ex_pipe_valid,
   output logic                       ex_pipe_ready,
   input  logic [XLEN-1:0]            ex_pc,
   input  logic [XLEN-1:0]            ex_instruction,
   input  logic [XLEN-1:0]            ex_immediate,
   input  logic [XLEN-1:0]            ex_rs1_rdata,
   input  logic [XLEN-1:0]            ex_rs2_rdata,
   input  logic [ALU_OP_WIDTH-1:0]    ex_alu_opcode,
   input  logic                       ex_alu_src1_sel_pc,
   input  logic                       ex_alu_src2_sel_imm,
   input  logic                       ex_branch,
   input  logic                       ex_jump,
   input  logic [BRANCH_OP_WIDTH-1:0] ex_branch_opcode,
   input  logic                       ex_rd_write,
   input  logic [REG_AW-1:0]          ex_rd_addr,
   input  logic                       ex_mem_read,
   input  logic                       ex_mem_write,
   input  logic [MEM_OP_WIDTH-1:0]    ex_mem_opcode,
   input  logic                       ex_unsign,
   output logic                       ex_redirect,
   output logic [XLEN-1:0]            ex_redirect_pc,
   output logic                       mem_pipe_valid,
   input  logic                       mem_pipe_ready,
   output logic [XLEN-1:0]            mem_pc,
   output logic [XLEN-1:0]            mem_instruction,
   output logic [XLEN-1:0]            mem_alu_result,
   output logic [XLEN-1:0]            mem_rs2_rdata,
   output logic                       mem_rd_write,
   output logic [REG_AW-1:0]          mem_rd_addr,
   output logic                       mem_mem_read,
   output logic                       mem_mem_write,
   output logic [MEM_OP_WIDTH-1:0]    mem_mem_opcode,
   output logic                       mem_unsign,
   output ex_mul_state_t              mul_state
);

   logic            fire, mul_ok, branch_taken;
   logic [XLEN-1:0] src1, src2, alu_result, result_d, jump_sum;
   logic [4:0]      shamt;

   assign src1  = ex_alu_src1_sel_pc  ? ex_pc        : ex_rs1_rdata;
   assign src2  = ex_alu_src2_sel_imm ? ex_immediate : ex_rs2_rdata;
   assign shamt = src2[4:0];

`ifdef RV32M_MUL_EN
   ex_mul_state_t   state_q, state_d;
   logic            is_mul;
   logic [XLEN-1:0] mul_result;

   assign is_mul = (ex_alu_opcode == ALU_OP_MUL)    || (ex_alu_opcode == ALU_OP_MULH) ||
                   (ex_alu_opcode == ALU_OP_MULHSU) || (ex_alu_opcode == ALU_OP_MULHU);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ID keeps the multiply bundle on the bus until it fires out of MUL2.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ex_pipe_valid && is_mul) state_d = MUL1;
         MUL1:    state_d = MUL2;
         MUL2:    if (fire) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mul_ok    = (state_q == IDLE) ? !is_mul : (state_q == MUL2);
   assign mul_state = state_q;

   ex_stage_mul u_mul (
      .clk    (clk),
      .rst_b  (rst_b),
      .start  ((state_q == IDLE) && ex_pipe_valid && is_mul),
      .step   (state_q == MUL1),
      .op     (ex_alu_opcode),
      .rs1    (ex_rs1_rdata),
      .rs2    (ex_rs2_rdata),
      .result (mul_result)
   );
`else
   assign mul_ok    = 1'b1;
   assign mul_state = IDLE;
`endif

   assign ex_pipe_ready = (!mem_pipe_valid || mem_pipe_ready) && mul_ok;
   assign fire          = ex_pipe_valid && ex_pipe_ready;

   always_comb begin
      alu_result = '0;
      case (ex_alu_opcode)
         ALU_OP_ADD:  alu_result = src1 + src2;
         ALU_OP_SUB:  alu_result = src1 - src2;
         ALU_OP_AND:  alu_result = src1 & src2;
         ALU_OP_OR:   alu_result = src1 | src2;
         ALU_OP_XOR:  alu_result = src1 ^ src2;
         ALU_OP_SLT:  alu_result = {31'd0, $signed(src1) < $signed(src2)};
         ALU_OP_SLTU: alu_result = {31'd0, src1 < src2};
         ALU_OP_SLL:  alu_result = src1 << shamt;
         ALU_OP_SRL:  alu_result = src1 >> shamt;
         ALU_OP_SRA:  alu_result = $unsigned($signed(src1) >>> shamt);
         ALU_OP_LUI:  alu_result = src2;
`ifdef RV32M_MUL_EN
         ALU_OP_MUL, ALU_OP_MULH, ALU_OP_MULHSU, ALU_OP_MULHU: alu_result = mul_result;
`endif
         default:     alu_result = '0;
      endcase
   end

   // Branches always compare the raw register operands, never the muxed ones.
   always_comb begin
      branch_taken = 1'b0;
      case (ex_branch_opcode)
         BRANCH_OP_BEQ:  branch_taken = (ex_rs1_rdata == ex_rs2_rdata);
         BRANCH_OP_BNE:  branch_taken = (ex_rs1_rdata != ex_rs2_rdata);
         BRANCH_OP_BLT:  branch_taken = ($signed(ex_rs1_rdata) <  $signed(ex_rs2_rdata));
         BRANCH_OP_BGE:  branch_taken = ($signed(ex_rs1_rdata) >= $signed(ex_rs2_rdata));
         BRANCH_OP_BLTU: branch_taken = (ex_rs1_rdata <  ex_rs2_rdata);
         BRANCH_OP_BGEU: branch_taken = (ex_rs1_rdata >= ex_rs2_rdata);
         default:        branch_taken = 1'b0;
      endcase
   end

   // src1 is pc for JAL and rs1 for JALR, so one adder serves both.
   assign jump_sum       = src1 + ex_immediate;
   assign ex_redirect    = fire && (ex_jump || (ex_branch && branch_taken));
   assign ex_redirect_pc = ex_jump ? {jump_sum[XLEN-1:1], 1'b0} : (ex_pc + ex_immediate);

   assign result_d = ex_jump                      ? ex_pc + 32'd4 :
                     (ex_mem_read || ex_mem_write) ? ex_rs1_rdata + ex_immediate :
                                                     alu_result;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         mem_pipe_valid  <= 1'b0;
         mem_pc          <= '0;
         mem_instruction <= '0;
         mem_alu_result  <= '0;
         mem_rs2_rdata   <= '0;
         mem_rd_write    <= 1'b0;
         mem_rd_addr     <= '0;
         mem_mem_read    <= 1'b0;
         mem_mem_write   <= 1'b0;
         mem_mem_opcode  <= '0;
         mem_unsign      <= 1'b0;
      end else if (fire) begin
         mem_pipe_valid  <= 1'b1;
         mem_pc          <= ex_pc;
         mem_instruction <= ex_instruction;
         mem_alu_result  <= result_d;
         mem_rs2_rdata   <= ex_rs2_rdata;
         mem_rd_write    <= ex_rd_write && !ex_branch;
         mem_rd_addr     <= ex_rd_addr;
         mem_mem_read    <= ex_mem_read;
         mem_mem_write   <= ex_mem_write;
         mem_mem_opcode  <= ex_mem_opcode;
         mem_unsign      <= ex_unsign;
      end else if (mem_pipe_ready) begin
         mem_pipe_valid  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;
  import ex_stage_pkg::*;

  localparam logic [3:0] OP_ADD = 4'd0, OP_MULH = 4'd12;

  typedef struct {
    logic [31:0] pc, instr, imm, rs1, rs2;
    logic [3:0]  op;
    logic        sel_pc, sel_imm, branch, jump;
    logic [2:0]  bop;
    logic        rd_write;
    logic [4:0]  rd_addr;
    logic        mem_read, mem_write;
    logic [2:0]  mem_op;
    logic        unsign;
  } txn_t;

  typedef struct {
    logic [31:0] pc, instr, result, rs2;
    logic        chk_result, rd_write;
    logic [4:0]  rd_addr;
    logic        mem_read, mem_write;
    logic [2:0]  mem_op;
    logic        unsign;
  } mem_exp_t;

  typedef struct {
    logic        redirect;
    logic [31:0] target;
  } redir_exp_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  logic ex_pipe_valid, ex_pipe_ready;
  logic [31:0] ex_pc, ex_instruction, ex_immediate, ex_rs1_rdata, ex_rs2_rdata;
  logic [3:0] ex_alu_opcode;
  logic ex_alu_src1_sel_pc, ex_alu_src2_sel_imm, ex_branch, ex_jump;
  logic [2:0] ex_branch_opcode;
  logic ex_rd_write;
  logic [4:0] ex_rd_addr;
  logic ex_mem_read, ex_mem_write;
  logic [2:0] ex_mem_opcode;
  logic ex_unsign;
  logic ex_redirect;
  logic [31:0] ex_redirect_pc;
  logic mem_pipe_valid, mem_pipe_ready;
  logic [31:0] mem_pc, mem_instruction, mem_alu_result, mem_rs2_rdata;
  logic mem_rd_write;
  logic [4:0] mem_rd_addr;
  logic mem_mem_read, mem_mem_write;
  logic [2:0] mem_mem_opcode;
  logic mem_unsign;
  ex_mul_state_t mul_state;

  ex_stage dut (
    .clk(clk), .rst_b(rst_b),
    .ex_pipe_valid(ex_pipe_valid), .ex_pipe_ready(ex_pipe_ready),
    .ex_pc(ex_pc), .ex_instruction(ex_instruction), .ex_immediate(ex_immediate),
    .ex_rs1_rdata(ex_rs1_rdata), .ex_rs2_rdata(ex_rs2_rdata),
    .ex_alu_opcode(ex_alu_opcode), .ex_alu_src1_sel_pc(ex_alu_src1_sel_pc),
    .ex_alu_src2_sel_imm(ex_alu_src2_sel_imm), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_branch_opcode(ex_branch_opcode), .ex_rd_write(ex_rd_write), .ex_rd_addr(ex_rd_addr),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_opcode(ex_mem_opcode),
    .ex_unsign(ex_unsign), .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .mem_pipe_valid(mem_pipe_valid), .mem_pipe_ready(mem_pipe_ready),
    .mem_pc(mem_pc), .mem_instruction(mem_instruction), .mem_alu_result(mem_alu_result),
    .mem_rs2_rdata(mem_rs2_rdata), .mem_rd_write(mem_rd_write), .mem_rd_addr(mem_rd_addr),
    .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
    .mem_mem_opcode(mem_mem_opcode), .mem_unsign(mem_unsign), .mul_state(mul_state)
  );

  // scoreboard state
  mem_exp_t   exp_q[$];
  redir_exp_t redir_q[$];
  int checks = 0;
  int errors = 0;
  logic force_en = 1'b1;
  logic force_val = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // reference model
  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic signed_lt(input logic [31:0] a, input logic [31:0] b);
    // flipping the sign bit maps two's complement order onto unsigned order
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  function automatic logic [31:0] model_alu(input txn_t t);
    logic [31:0] a, b;
    logic [63:0] wide;
    longint p;
    a = t.sel_pc ? t.pc : t.rs1;
    b = t.sel_imm ? t.imm : t.rs2;
    p = 0;
    case (t.op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return {31'd0, signed_lt(a, b)};
      4'd6:  return {31'd0, a < b};
      4'd7:  return a << b[4:0];
      4'd8:  return a >> b[4:0];
      4'd9:  begin wide = {{32{a[31]}}, a} >> b[4:0]; return wide[31:0]; end
      4'd10: return b;
`ifdef RV32M_MUL_EN
      4'd11: begin p = longint'($signed(t.rs1)) * longint'($signed(t.rs2)); return p[31:0]; end
      4'd12: begin p = longint'($signed(t.rs1)) * longint'($signed(t.rs2)); return p[63:32]; end
      4'd13: begin p = longint'($signed(t.rs1)) * longint'({32'd0, t.rs2}); return p[63:32]; end
      4'd14: begin wide = {32'd0, t.rs1} * {32'd0, t.rs2}; return wide[63:32]; end
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic model_taken(input txn_t t);
    case (t.bop)
      3'd0: return t.rs1 == t.rs2;
      3'd1: return t.rs1 != t.rs2;
      3'd4: return signed_lt(t.rs1, t.rs2);
      3'd5: return !signed_lt(t.rs1, t.rs2);
      3'd6: return t.rs1 < t.rs2;
      3'd7: return !(t.rs1 < t.rs2);
      default: return 1'b0;
    endcase
  endfunction

  function automatic mem_exp_t model_mem(input txn_t t);
    mem_exp_t e;
    e.pc = t.pc; e.instr = t.instr; e.rs2 = t.rs2;
    e.rd_write = t.rd_write && !t.branch; e.rd_addr = t.rd_addr;
    e.mem_read = t.mem_read; e.mem_write = t.mem_write; e.mem_op = t.mem_op; e.unsign = t.unsign;
    e.chk_result = !t.branch;
    if (t.jump) e.result = t.pc + 32'd4;
    else if (t.mem_read || t.mem_write) e.result = t.rs1 + t.imm;
    else e.result = model_alu(t);
    return e;
  endfunction

  function automatic redir_exp_t model_redir(input txn_t t);
    redir_exp_t r;
    r.redirect = 1'b0; r.target = 32'd0;
    if (t.jump) begin
      r.redirect = 1'b1;
      r.target = ((t.sel_pc ? t.pc : t.rs1) + t.imm) & 32'hFFFF_FFFE;
    end else if (t.branch) begin
      r.redirect = model_taken(t);
      r.target = t.pc + t.imm;
    end
    return r;
  endfunction

  function automatic txn_t blank_txn();
    txn_t t;
    t.pc = 0; t.instr = 0; t.imm = 0; t.rs1 = 0; t.rs2 = 0; t.op = OP_ADD;
    t.sel_pc = 0; t.sel_imm = 0; t.branch = 0; t.jump = 0; t.bop = 0;
    t.rd_write = 0; t.rd_addr = 0; t.mem_read = 0; t.mem_write = 0; t.mem_op = 0; t.unsign = 0;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t = blank_txn();
    t.pc = $urandom() & 32'hFFFF_FFFC; t.instr = $urandom();
    t.imm = rnd_word(); t.rs1 = rnd_word(); t.rs2 = rnd_word();
    t.rd_write = 1'($urandom_range(0, 1)); t.rd_addr = 5'($urandom_range(0, 31));
    t.mem_op = 3'($urandom_range(0, 2)); t.unsign = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0, 1: begin
        t.op = 4'($urandom_range(0, 15));
        t.sel_pc = 1'($urandom_range(0, 1)); t.sel_imm = 1'($urandom_range(0, 1));
      end
      2: begin
        t.branch = 1; t.bop = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) t.rs2 = t.rs1;
      end
      3: begin t.jump = 1; t.sel_pc = 1; t.sel_imm = 1; end
      4: begin t.jump = 1; t.sel_imm = 1; end
      default: begin
        if ($urandom_range(0, 1) == 1) t.mem_read = 1; else t.mem_write = 1;
        t.sel_imm = 1;
      end
    endcase
    return t;
  endfunction

  // driver tasks
  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  task automatic drive(input txn_t t);
    ex_pc = t.pc; ex_instruction = t.instr; ex_immediate = t.imm;
    ex_rs1_rdata = t.rs1; ex_rs2_rdata = t.rs2; ex_alu_opcode = t.op;
    ex_alu_src1_sel_pc = t.sel_pc; ex_alu_src2_sel_imm = t.sel_imm;
    ex_branch = t.branch; ex_jump = t.jump; ex_branch_opcode = t.bop;
    ex_rd_write = t.rd_write; ex_rd_addr = t.rd_addr; ex_mem_read = t.mem_read;
    ex_mem_write = t.mem_write; ex_mem_opcode = t.mem_op; ex_unsign = t.unsign;
  endtask

  task automatic wait_accept(output int waits);
    bit ok;
    ok = 0; waits = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ex_pipe_ready) begin ok = 1; break; end
      waits++;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual=ready_low expected=accept_within_60");
      finish_run();
    end
    @(posedge clk); #1;
    ex_pipe_valid = 1'b0;
  endtask

  task automatic send(input txn_t t, output int waits);
    drive(t);
    exp_q.push_back(model_mem(t));
    redir_q.push_back(model_redir(t));
    ex_pipe_valid = 1'b1;
    wait_accept(waits);
  endtask

  task automatic drain();
    force_en = 1'b1; force_val = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // downstream ready
  initial begin
    mem_pipe_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      mem_pipe_ready = force_en ? force_val : ($urandom_range(0, 3) != 0);
    end
  end

  // monitor
  initial begin
    mem_exp_t e;
    redir_exp_t r;
    forever begin
      @(negedge clk);
      if (rst_b) begin
        if (mem_pipe_valid && mem_pipe_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL mem_unexpected actual=valid expected=no_output");
          end else begin
            e = exp_q.pop_front();
            check("mem_pc", mem_pc, e.pc);
            check("mem_instruction", mem_instruction, e.instr);
            if (e.chk_result) check("mem_alu_result", mem_alu_result, e.result);
            check("mem_rs2_rdata", mem_rs2_rdata, e.rs2);
            check("mem_rd_write", 32'(mem_rd_write), 32'(e.rd_write));
            check("mem_rd_addr", 32'(mem_rd_addr), 32'(e.rd_addr));
            check("mem_mem_read", 32'(mem_mem_read), 32'(e.mem_read));
            check("mem_mem_write", 32'(mem_mem_write), 32'(e.mem_write));
            check("mem_mem_opcode", 32'(mem_mem_opcode), 32'(e.mem_op));
            check("mem_unsign", 32'(mem_unsign), 32'(e.unsign));
          end
        end
        if (ex_pipe_valid && ex_pipe_ready) begin
          if (redir_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL fire_unexpected actual=fire expected=no_fire");
          end else begin
            r = redir_q.pop_front();
            check("ex_redirect", 32'(ex_redirect), 32'(r.redirect));
            if (r.redirect) check("ex_redirect_pc", ex_redirect_pc, r.target);
          end
        end else begin
          check("no_redirect_without_fire", 32'(ex_redirect), 32'd0);
        end
      end
    end
  end

  // stimulus
  initial begin
    txn_t t;
    int waits;
    ex_pipe_valid = 1'b0;
    drive(blank_txn());
    #1 rst_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_pipe_valid", 32'(mem_pipe_valid), 32'd0);
    check("rst_mem_alu_result", mem_alu_result, 32'd0);
    check("rst_mem_pc", mem_pc, 32'd0);
    check("rst_mem_rd_write", 32'(mem_rd_write), 32'd0);
    check("rst_mul_state", 32'(mul_state), 32'(IDLE));
    check("rst_ex_redirect", 32'(ex_redirect), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
    @(posedge clk); #1;

    // ADD wrap-around
    t = blank_txn(); t.rs1 = 32'hFFFF_FFFF; t.imm = 32'd1; t.sel_imm = 1; t.rd_write = 1; t.rd_addr = 5'd3;
    send(t, waits);
    check("add_no_stall", 32'(waits), 32'd0);
    // BLT taken, then BLTU not taken on the same operands
    t = blank_txn(); t.branch = 1; t.bop = BRANCH_OP_BLT; t.rs1 = 32'hFFFF_FFFF; t.rs2 = 32'd1;
    t.pc = 32'h100; t.imm = 32'hFFFF_FFF8; t.rd_write = 1;
    send(t, waits);
    t.bop = BRANCH_OP_BLTU;
    send(t, waits);
    // JALR clears bit 0 of the target
    t = blank_txn(); t.jump = 1; t.sel_imm = 1; t.rs1 = 32'h2003; t.pc = 32'h40; t.rd_write = 1; t.rd_addr = 5'd1;
    send(t, waits);
    // MULH 0x8000_0000 x 2
    drain();
    t = blank_txn(); t.op = OP_MULH; t.rs1 = 32'h8000_0000; t.rs2 = 32'd2; t.rd_write = 1;
    send(t, waits);
`ifdef RV32M_MUL_EN
    check("mulh_ready_low_cycles", 32'(waits), 32'd2);
`else
    check("mul_opcode_single_cycle", 32'(waits), 32'd0);
`endif

    // downstream stall with a jump waiting
    drain();
    force_val = 1'b0;
    @(posedge clk); #1;
    t = blank_txn(); t.rs1 = 32'h1234_0000; t.imm = 32'h0000_5678; t.sel_imm = 1; t.pc = 32'h200;
    send(t, waits);
    t = blank_txn(); t.jump = 1; t.sel_pc = 1; t.sel_imm = 1; t.pc = 32'h300; t.imm = 32'h40; t.rd_write = 1;
    drive(t);
    exp_q.push_back(model_mem(t));
    redir_q.push_back(model_redir(t));
    ex_pipe_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_ex_pipe_ready", 32'(ex_pipe_ready), 32'd0);
      check("stall_ex_redirect", 32'(ex_redirect), 32'd0);
      check("stall_mem_pipe_valid", 32'(mem_pipe_valid), 32'd1);
      check("stall_mem_alu_result", mem_alu_result, 32'h1234_5678);
      check("stall_mem_pc", mem_pc, 32'h200);
    end
    force_val = 1'b1;
    wait_accept(waits);

    // reset in the middle of an operation
    drain();
`ifdef RV32M_MUL_EN
    t = blank_txn(); t.op = OP_MULH; t.rs1 = 32'h8000_0000; t.rs2 = 32'd2; t.rd_write = 1;
    drive(t);
    ex_pipe_valid = 1'b1;
    @(posedge clk); #1;
    check("mul1_entered", 32'(mul_state), 32'(MUL1));
    rst_b = 1'b0;
    #1;
    check("midmul_rst_mem_pipe_valid", 32'(mem_pipe_valid), 32'd0);
    check("midmul_rst_mul_state", 32'(mul_state), 32'(IDLE));
    check("midmul_rst_ex_redirect", 32'(ex_redirect), 32'd0);
    @(negedge clk); #1;
    rst_b = 1'b1;
    exp_q.push_back(model_mem(t));
    redir_q.push_back(model_redir(t));
    wait_accept(waits);
`else
    force_val = 1'b0;
    @(posedge clk); #1;
    t = blank_txn(); t.rs1 = 32'h55; t.imm = 32'h11; t.sel_imm = 1; t.pc = 32'h80;
    send(t, waits);
    rst_b = 1'b0;
    #1;
    check("midrun_rst_mem_pipe_valid", 32'(mem_pipe_valid), 32'd0);
    check("midrun_rst_mem_alu_result", mem_alu_result, 32'd0);
    check("midrun_rst_mem_pc", mem_pc, 32'd0);
    exp_q.delete();
    @(negedge clk); #1;
    rst_b = 1'b1;
    force_val = 1'b1;
    @(posedge clk); #1;
`endif

    // random traffic with random downstream back-pressure
    force_en = 1'b0;
    for (int n = 0; n < 400; n++) begin
      send(rand_txn(), waits);
      if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
    end
    drain();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("redir_q_empty", 32'(redir_q.size()), 32'd0);
    finish_run();
  end

endmodule
